// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared constants and address decode for the data-side
// responder (RAM window plus the MMIO registers at 0xFF00..0xFF02).
package dmem_mmio_pkg;

  localparam logic [15:0] MMIO_TXDATA = 16'hFF00;
  localparam logic [15:0] MMIO_STATUS = 16'hFF01;
  localparam logic [15:0] MMIO_TIMER  = 16'hFF02;

  // STATUS layout: {count[7:0], 5'b0, overflow, full, empty}
  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_TXDATA,
    REGION_STATUS,
    REGION_TIMER
  } mmioRegion_e;

  // The RAM window always sits below 0xFF00, so the order of these tests
  // never matters; anything unmatched reads as zero and ignores writes.
  function automatic mmioRegion_e decodeRegion(input logic [15:0] addr,
                                               input logic [16:0] ramLimit);
    if ({1'b0, addr} < ramLimit) return REGION_RAM;
    if (addr == MMIO_TXDATA)     return REGION_TXDATA;
    if (addr == MMIO_STATUS)     return REGION_STATUS;
    if (addr == MMIO_TIMER)      return REGION_TIMER;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: MEM-stage load/store bus plus the TX valid/ready stream.
// The master side is the CPU/consumer, the slave side is dmem_mmio.
interface dmem_mmio_if;

  logic [15:0] addr;
  logic [15:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] read_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, write_data, mem_write, mem_read, tx_ready,
    input  read_data, tx_data, tx_valid
  );

  modport slave (
    input  addr, write_data, mem_write, mem_read, tx_ready,
    output read_data, tx_data, tx_valid
  );

endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO with power-of-two depth. A push while full is
// accepted only if a pop frees a slot in the same cycle; otherwise the word
// is dropped and the caller decides what to do about it.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int CountW = PtrW + 1;

  logic [WIDTH-1:0]  storage [DEPTH];
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = storage[rdPtr_q];

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || pop_i);

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PtrW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PtrW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (doPush && !rst) storage[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus MMIO window (TX FIFO, STATUS, optional TIMER)
// answering the CPU MEM stage. Loads are combinational, stores commit at
// the rising edge.
// Build option: define DMEM_TIMER_EN to include the free-running cycle timer
// at 0xFF02; without it that address reads zero and ignores writes.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  dmem_mmio_if.slave bus
);

  localparam int              RamAw    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [16:0]     RamLimit = 17'(RAM_DEPTH);
  localparam int              CountW   = $clog2(FIFO_DEPTH) + 1;

  mmioRegion_e       region;
  logic [15:0]       ram [RAM_DEPTH];
  logic              ramWe;
  logic              pushReq;
  logic              popReq;
  logic              statusWrite;
  logic [15:0]       fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CountW-1:0] fifoCount;
  logic [7:0]        countByte;
  logic              overflow_q, overflow_d;
  logic [15:0]       statusWord;
  logic [15:0]       timerValue;
  logic [15:0]       readValue;

  assign region = decodeRegion(bus.addr, RamLimit);

  // RAM stores are not blocked by reset; MMIO side effects are.
  assign ramWe       = bus.mem_write && (region == REGION_RAM);
  assign pushReq     = bus.mem_write && (region == REGION_TXDATA) && !rst;
  assign statusWrite = bus.mem_write && (region == REGION_STATUS) && !rst;

  assign bus.tx_valid = !fifoEmpty;
  assign bus.tx_data  = fifoEmpty ? 16'h0000 : fifoHead;
  assign popReq       = bus.tx_valid && bus.tx_ready;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_txFifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pushReq),
    .pushData_i (bus.write_data),
    .pop_i      (popReq),
    .head_o     (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Word RAM: synchronous write, contents survive reset.
  always_ff @(posedge clk) begin
    if (ramWe) ram[bus.addr[RamAw-1:0]] <= bus.write_data;
  end

  // Sticky overflow: set by a dropped push, cleared by any STATUS write,
  // and the clear wins if both happen together.
  always_comb begin
    overflow_d = overflow_q;
    if (statusWrite) begin
      overflow_d = 1'b0;
    end else if (pushReq && fifoFull && !popReq) begin
      overflow_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

`ifdef DMEM_TIMER_EN
  logic [15:0] timer_q, timer_d;
  logic        timerWrite;

  assign timerWrite = bus.mem_write && (region == REGION_TIMER) && !rst;

  // Free-running counter; a store loads it instead of incrementing.
  always_comb begin
    timer_d = timer_q + 16'd1;
    if (timerWrite) timer_d = bus.write_data;
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  assign timerValue = timer_q;
`else
  assign timerValue = 16'h0000;
`endif

  assign countByte = 8'(fifoCount);

  // Assemble the STATUS word from the live FIFO flags.
  always_comb begin
    statusWord = '0;
    statusWord[STATUS_EMPTY_BIT]         = fifoEmpty;
    statusWord[STATUS_FULL_BIT]          = fifoFull;
    statusWord[STATUS_OVERFLOW_BIT]      = overflow_q;
    statusWord[STATUS_COUNT_LSB +: 8]    = countByte;
  end

  // Load mux; TXDATA and unmapped addresses read zero, reads have no effects.
  always_comb begin
    readValue = 16'h0000;
    case (region)
      REGION_RAM:    readValue = ram[bus.addr[RamAw-1:0]];
      REGION_STATUS: readValue = statusWord;
      REGION_TIMER:  readValue = timerValue;
      default:       readValue = 16'h0000;
    endcase
  end

  assign bus.read_data = (bus.mem_read && !rst) ? readValue : 16'h0000;

endmodule
